key_cmd_scheduler: RTL
======================

KEY_CMD_SCHEDULER -- requirements
Module: key_cmd_scheduler

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- REPEAT_DELAY, 50_000_000: cycles from a held key's make to its first auto-repeat.
- REPEAT_PERIOD, 10_000_000: cycles between subsequent auto-repeats.
- FIFO_DEPTH, 4: command queue entries.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, input, 1: single clock; all state on its rising edge.
- rst, input, 1: reset, synchronous and active-high.
- key_valid, input, 1: one-cycle pulse marking a decoded key event.
- last_change, input, 9: {extend, scancode} of the event.
- key_down, input, 512: key-state vector, already updated in the key_valid cycle.
- cmd_ready, input, 1: consumer accepts the command.
- cmd_valid, output, 1: queue head valid.
- cmd, output, 4: one-hot direction; 0001 up, 0010 down, 0100 left, 1000 right.
- held_dir, output, 4: direction currently auto-repeating, 0000 if none.
- fifo_count, output, 3: queue occupancy, 0 to 4.
- overflow, output, 1: sticky flag, set when a push is dropped.

Function
REQ-003 Mapped codes SHALL be 9'h01D up, 9'h01B down, 9'h01C left and 9'h023 right; all other codes SHALL be ignored.
REQ-004 A make event SHALL be key_valid=1, a mapped last_change, and key_down[last_change]=1. A break event is the same with key_down[last_change]=0.
REQ-005 A make SHALL push its direction, set held_dir, load the repeat counter and enter DELAY, including when it replaces a different held key (last pressed wins).
REQ-006 A break SHALL clear held_dir and enter IDLE only if it matches held_dir; any other break SHALL be ignored.
REQ-007 Repeat FSM states and transitions:
- IDLE: no pushes.
- DELAY: after REPEAT_DELAY cycles, push held_dir and go to REPEAT.
- REPEAT: push held_dir every REPEAT_PERIOD cycles.
- Counter width: clog2 of the larger of REPEAT_DELAY and REPEAT_PERIOD.
REQ-008 If a key event and a counter expiry fall in the same cycle, the key event SHALL win and the repeat push SHALL be dropped without setting overflow. A make reloads the counter; a matching break returns to IDLE.
REQ-009 The FIFO SHALL be first-in first-out with no bypass. A push with an empty FIFO SHALL raise cmd_valid on the next cycle, giving key_valid-to-cmd_valid latency of 1.
REQ-010 Pop SHALL occur when cmd_valid and cmd_ready are both 1. cmd SHALL stay stable while cmd_valid=1 and cmd_ready=0.
REQ-011 Full-FIFO behaviour:
- Push with no pop SHALL be dropped and set overflow.
- Push together with a pop SHALL be accepted, and fifo_count SHALL stay 4.
REQ-012 Push and pop in the same cycle with 0 < fifo_count < 4 SHALL leave fifo_count unchanged.
REQ-013 Pointers SHALL wrap modulo FIFO_DEPTH. cmd_valid SHALL equal (fifo_count != 0).
REQ-014 key_valid asserted with an unmapped code SHALL change no state.

Reset
REQ-015 While rst=1 at a clk edge, the block SHALL set:
- cmd_valid=0, cmd=0000, held_dir=0000, fifo_count=0, overflow=0.
- FSM to IDLE, repeat counter to 0, pointers to 0.
REQ-016 rst asserted mid-operation SHALL discard queued commands and any pending repeat. The first cycle after reset SHALL accept events normally.

Structure
REQ-017 Package key_cmd_pkg SHALL hold:
- the four key-code constants;
- the one-hot direction constants;
- the repeat FSM state enum (IDLE, DELAY, REPEAT).
REQ-018 The queue SHALL be a sub-module cmd_fifo: synchronous, 4 bits wide, FIFO_DEPTH deep, with push/pop/full/empty/count. The top level holds the decode logic and the repeat FSM.

Verification (REPEAT_DELAY=8, REPEAT_PERIOD=4)
REQ-019 Make 01D then break 01D after 3 cycles, cmd_ready=1 -> exactly one cmd=0001, cmd_valid high 1 cycle after key_valid, no repeat.
REQ-020 Make 023 held 20 cycles, cmd_ready=1 -> cmd=1000 at t+1, then repeats at t+9, t+13, t+17; break clears held_dir.
REQ-021 cmd_ready=0, six makes alternating 01B/01C -> fifo_count=4, overflow=1, draining yields 0010, 0100, 0010, 0100.
REQ-022 FIFO full with a push and pop in the same cycle -> fifo_count stays 4, overflow stays 0, new entry is last out.
REQ-023 Make 01D, then make 01C at cycle 5 -> held_dir=0100, the next repeat is 0100 at 8 cycles after the second make, and a later break of 01D is ignored.
REQ-024 rst pulsed with 3 queued commands and FSM in REPEAT -> all outputs zero next cycle; a make in the following cycle is queued normally.

Source files
------------

// File: rtl/key_cmd_pkg.sv
// Shared constants, repeat-FSM state type and scancode decode for the key command scheduler.
package key_cmd_pkg;

  localparam logic [8:0] CODE_UP    = 9'h01D;
  localparam logic [8:0] CODE_DOWN  = 9'h01B;
  localparam logic [8:0] CODE_LEFT  = 9'h01C;
  localparam logic [8:0] CODE_RIGHT = 9'h023;

  localparam logic [3:0] DIR_NONE  = 4'b0000;
  localparam logic [3:0] DIR_UP    = 4'b0001;
  localparam logic [3:0] DIR_DOWN  = 4'b0010;
  localparam logic [3:0] DIR_LEFT  = 4'b0100;
  localparam logic [3:0] DIR_RIGHT = 4'b1000;

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rep_state_e;

  // Unmapped codes decode to DIR_NONE, which callers treat as "ignore".
  function automatic logic [3:0] code_to_dir(input logic [8:0] code);
    case (code)
      CODE_UP:    return DIR_UP;
      CODE_DOWN:  return DIR_DOWN;
      CODE_LEFT:  return DIR_LEFT;
      CODE_RIGHT: return DIR_RIGHT;
      default:    return DIR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command queue; head is read straight from storage, reads zero when empty.
module cmd_fifo
  import key_cmd_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [3:0]       data_i,
  input  logic             pop_i,
  output logic [3:0]       data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [3:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = empty_o ? DIR_NONE : mem_q[rd_ptr_q];

  // A push into a full queue is only taken when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    if (do_push) wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= DIR_NONE;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/key_cmd_scheduler.sv
// Turns arrow-key make/break events into direction commands with typematic auto-repeat,
// queued for a consumer through a small FIFO.
module key_cmd_scheduler
  import key_cmd_pkg::*;
#(
  parameter int unsigned REPEAT_DELAY  = 50_000_000,
  parameter int unsigned REPEAT_PERIOD = 10_000_000,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  input  logic [8:0]   last_change,
  input  logic [511:0] key_down,
  input  logic         cmd_ready,
  output logic         cmd_valid,
  output logic [3:0]   cmd,
  output logic [3:0]   held_dir,
  output logic [2:0]   fifo_count,
  output logic         overflow
);

  localparam int unsigned MAX_CYC = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int unsigned FCNT_W  = $clog2(FIFO_DEPTH + 1);

  rep_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        held_q, held_d;
  logic              overflow_q, overflow_d;

  logic [3:0]        ev_dir_c;
  logic              make_c, brk_c;
  logic              push_c, pop_c;
  logic [3:0]        push_dir_c;
  logic              full_c, empty_c;
  logic [FCNT_W-1:0] fcount_c;

  assign ev_dir_c = code_to_dir(last_change);
  assign make_c   = key_valid && (ev_dir_c != DIR_NONE) && key_down[last_change];
  // Only releasing the key that is currently repeating stops the repeat.
  assign brk_c    = key_valid && (ev_dir_c != DIR_NONE) && !key_down[last_change]
                    && (ev_dir_c == held_q);
  assign pop_c    = cmd_valid && cmd_ready;

  // Key events take priority over a counter expiry in the same cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    held_d     = held_q;
    push_c     = 1'b0;
    push_dir_c = DIR_NONE;
    if (make_c) begin
      push_c     = 1'b1;
      push_dir_c = ev_dir_c;
      held_d     = ev_dir_c;
      cnt_d      = CNT_W'(REPEAT_DELAY - 1);
      state_d    = DELAY;
    end else if (brk_c) begin
      held_d  = DIR_NONE;
      cnt_d   = '0;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: cnt_d = '0;
        DELAY, REPEAT: begin
          if (cnt_q == '0) begin
            push_c     = 1'b1;
            push_dir_c = held_q;
            cnt_d      = CNT_W'(REPEAT_PERIOD - 1);
            state_d    = REPEAT;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
    overflow_d = overflow_q || (push_c && full_c && !pop_c);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      held_q     <= DIR_NONE;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      held_q     <= held_d;
      overflow_q <= overflow_d;
    end
  end

  cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (FCNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_c),
    .data_i  (push_dir_c),
    .pop_i   (pop_c),
    .data_o  (cmd),
    .full_o  (full_c),
    .empty_o (empty_c),
    .count_o (fcount_c)
  );

  assign cmd_valid  = !empty_c;
  assign held_dir   = held_q;
  assign fifo_count = 3'(fcount_c);
  assign overflow   = overflow_q;

endmodule
